rvhazard_unit: RTL and testbench

Hazard control unit for the 5-stage RV32I pipeline. It generates operand-forwarding selects, fetch/decode/execute stall and flush controls, and sequencing for multi-cycle execute operations such as MUL/DIV. It sits beside the datapath, is fed by the D/E/M/W pipeline-register fields, and drives the pipeline-register enables and clears. Two saturating performance counters report stall cycles and taken-redirect flushes.

---
 rtl/rvhazard_pkg.sv | 10 +
 rtl/rvhazard_if.sv | 17 +
 rtl/rvhazard_mcctl.sv | 43 ++++
 rtl/rvhazard_unit.sv | 43 ++++
 tb/tb_rvhazard_unit.sv | 130 +++++++++++++
 5 files changed

// File: rtl/rvhazard_pkg.sv
// rvhazard_pkg: shared types, constants and forwarding select helper for the hazard unit
package rvhazard_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_sel_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mc_state_t;
  localparam logic [4:0] X0 = 5'd0;
  function automatic fwd_sel_t fwd_sel(input logic [4:0] rs, rd_m, rd_w, input logic we_m, we_w);
    return (we_m && rd_m != X0 && rd_m == rs) ? FWD_M :
           (we_w && rd_w != X0 && rd_w == rs) ? FWD_W : FWD_RF;
  endfunction
endpackage

// File: rtl/rvhazard_if.sv
// rvhazard_if: pipeline-field inputs and stall/flush/forward controls of the hazard unit
interface rvhazard_if #(parameter int CNT_W = 32);
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic PCSrcE, MulStartE, RegWriteM, RegWriteW;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic [CNT_W-1:0] StallCount, FlushCount;
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE, PCSrcE, MulStartE, RegWriteM, RegWriteW,
    input ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, StallCount, FlushCount
  );
  modport slave (
    input Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE, PCSrcE, MulStartE, RegWriteM, RegWriteW,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, StallCount, FlushCount
  );
endinterface

// File: rtl/rvhazard_mcctl.sv
// rvhazard_mcctl: multi-cycle execute sequencer, stalls an op for MUL_LAT-1 cycles then one DONE cycle
module rvhazard_mcctl
  import rvhazard_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic MulStartE,
  output logic mcStall
);
  // BUSY runs load+1 cycles, so load = MUL_LAT-3 gives MUL_LAT-2 BUSY cycles
  localparam logic [3:0] LOAD = 4'(MUL_LAT > 2 ? MUL_LAT - 3 : 0);
  mc_state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    mcStall = 1'b0;
    case (state)
      IDLE: if (MulStartE) begin
        mcStall = 1'b1;
        state_n = (MUL_LAT == 2) ? DONE : BUSY;
        cnt_n = LOAD;
      end
      BUSY: begin
        mcStall = 1'b1;
        cnt_n = (cnt == '0) ? '0 : cnt - 4'd1;
        state_n = (cnt == '0) ? DONE : BUSY;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/rvhazard_unit.sv
// rvhazard_unit: RV32I 5-stage hazard control - forwarding, load-use/redirect/multi-cycle stalls, event counters
module rvhazard_unit
  import rvhazard_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  rvhazard_if.slave hz
);
  logic mc_stall, lw_stall, stall_d, unused;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  rvhazard_mcctl #(.MUL_LAT(MUL_LAT)) u_mcctl (
    .clk(clk),
    .reset(reset),
    .MulStartE(hz.MulStartE),
    .mcStall(mc_stall)
  );
  assign unused = hz.ResultSrcE[1];
  assign lw_stall = hz.ResultSrcE[0] && hz.RdE != X0 && (hz.Rs1D == hz.RdE || hz.Rs2D == hz.RdE) && !mc_stall;
  // a taken redirect squashes the load-use hold; the younger instructions are discarded anyway
  assign stall_d = reset && (mc_stall || (lw_stall && !hz.PCSrcE));
  assign hz.ForwardAE = reset ? fwd_sel(hz.Rs1E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW) : FWD_RF;
  assign hz.ForwardBE = reset ? fwd_sel(hz.Rs2E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW) : FWD_RF;
  assign hz.StallF = stall_d;
  assign hz.StallD = stall_d;
  assign hz.StallE = reset && mc_stall;
  assign hz.FlushD = !reset || hz.PCSrcE;
  assign hz.FlushE = !reset || hz.PCSrcE || lw_stall;
  assign hz.FlushM = !reset || mc_stall;
  assign hz.StallCount = stall_cnt;
  assign hz.FlushCount = flush_cnt;
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_d && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (hz.PCSrcE && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_rvhazard_unit.sv
// tb_rvhazard_unit: directed scoreboard bench for rvhazard_unit (MUL_LAT=4 and MUL_LAT=2, 4-bit counters)
module tb_rvhazard_unit;
  import rvhazard_pkg::*;
  typedef struct {
    string tag;
    logic [1:0] fa, fb;
    logic sf, sd, se, fd, fe, fm;
    logic [3:0] sc, fc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];
  logic q2[$];
  always #5 clk = ~clk;
  rvhazard_if #(.CNT_W(4)) h4 ();
  rvhazard_if #(.CNT_W(4)) h2 ();
  rvhazard_unit #(.MUL_LAT(4), .CNT_W(4)) dut4 (.clk(clk), .reset(reset), .hz(h4));
  rvhazard_unit #(.MUL_LAT(2), .CNT_W(4)) dut2 (.clk(clk), .reset(reset), .hz(h2));
  task automatic chk(input string tag, input string f, input logic [3:0] o, input logic [3:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, f, o, e);
    end
  endtask
  task automatic clr();
    h4.Rs1D = 0; h4.Rs2D = 0; h4.Rs1E = 0; h4.Rs2E = 0; h4.RdE = 0; h4.RdM = 0; h4.RdW = 0;
    h4.ResultSrcE = 0; h4.PCSrcE = 0; h4.MulStartE = 0; h4.RegWriteM = 0; h4.RegWriteW = 0;
  endtask
  task automatic cyc(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                     input logic sf, input logic sd, input logic se,
                     input logic fd, input logic fe, input logic fm,
                     input logic [3:0] sc, input logic [3:0] fc);
    exp_t e, x;
    e.tag = tag; e.fa = fa; e.fb = fb; e.sf = sf; e.sd = sd; e.se = se;
    e.fd = fd; e.fe = fe; e.fm = fm; e.sc = sc; e.fc = fc;
    q.push_back(e);
    @(negedge clk);
    x = q.pop_front();
    chk(x.tag, "ForwardAE", 4'(h4.ForwardAE), 4'(x.fa));
    chk(x.tag, "ForwardBE", 4'(h4.ForwardBE), 4'(x.fb));
    chk(x.tag, "StallF", 4'(h4.StallF), 4'(x.sf));
    chk(x.tag, "StallD", 4'(h4.StallD), 4'(x.sd));
    chk(x.tag, "StallE", 4'(h4.StallE), 4'(x.se));
    chk(x.tag, "FlushD", 4'(h4.FlushD), 4'(x.fd));
    chk(x.tag, "FlushE", 4'(h4.FlushE), 4'(x.fe));
    chk(x.tag, "FlushM", 4'(h4.FlushM), 4'(x.fm));
    chk(x.tag, "StallCount", h4.StallCount, x.sc);
    chk(x.tag, "FlushCount", h4.FlushCount, x.fc);
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [3:0] sc;
    logic st, e2;
    clr();
    h2.Rs1D = 0; h2.Rs2D = 0; h2.Rs1E = 0; h2.Rs2E = 0; h2.RdE = 0; h2.RdM = 0; h2.RdW = 0;
    h2.ResultSrcE = 0; h2.PCSrcE = 0; h2.MulStartE = 0; h2.RegWriteM = 0; h2.RegWriteW = 0;
    repeat (2) @(posedge clk);
    #1;
    // reset dominates every other input
    h4.Rs1E = 5; h4.RdM = 5; h4.RegWriteM = 1; h4.MulStartE = 1;
    h4.ResultSrcE = 2'b01; h4.RdE = 7; h4.Rs2D = 7; h4.PCSrcE = 1;
    cyc("reset", 2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 0, 0);
    clr();
    reset = 1'b1;
    cyc("idle", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    h4.RdM = 5; h4.RdW = 5; h4.RegWriteM = 1; h4.RegWriteW = 1; h4.Rs1E = 5;
    cyc("fwd_m", 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    h4.RegWriteM = 0; h4.Rs2E = 5;
    cyc("fwd_w", 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
    h4.RegWriteM = 1; h4.Rs1E = 0; h4.Rs2E = 0; h4.RdM = 0; h4.RdW = 0;
    cyc("fwd_x0", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    h4.RdM = 9; h4.RdW = 9; h4.Rs2E = 9; h4.Rs1E = 3;
    cyc("fwd_b_prio", 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
    clr();
    h4.ResultSrcE = 2'b01; h4.RdE = 7; h4.Rs2D = 7;
    cyc("lu", 2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 0);
    h4.ResultSrcE = 2'b00;
    cyc("lu_done", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
    h4.ResultSrcE = 2'b01; h4.RdE = 0; h4.Rs2D = 0; h4.Rs1D = 0;
    cyc("lu_rd0", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
    h4.RdE = 7; h4.Rs1D = 7; h4.PCSrcE = 1;
    cyc("redir_lu", 2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 1, 0);
    clr();
    cyc("redir_done", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1);
    sc = 4'd1;
    for (int i = 0; i < 8; i++) begin
      clr();
      h4.MulStartE = 1;
      if (i == 1) begin
        h4.ResultSrcE = 2'b01; h4.RdE = 7; h4.Rs1D = 7;
      end
      st = (i % 4) != 3;
      cyc($sformatf("mc4_%0d", i), 2'b00, 2'b00, st, st, st, 0, 0, st, sc, 1);
      if (st) sc++;
    end
    clr();
    cyc("mc4_idle", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 7, 1);
    h4.MulStartE = 1;
    cyc("mid_idle", 2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 7, 1);
    cyc("mid_busy1", 2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 8, 1);
    reset = 1'b0;
    cyc("mid_rst", 2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 9, 1);
    cyc("mid_rst2", 2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 0, 0);
    reset = 1'b1;
    h4.MulStartE = 0;
    cyc("post_rst", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("post_rst2", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    h4.ResultSrcE = 2'b01; h4.RdE = 7; h4.Rs1D = 7;
    for (int i = 0; i < 18; i++) cyc($sformatf("sat_%0d", i), 2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 4'(i > 15 ? 15 : i), 0);
    clr();
    // MUL_LAT = 2: one stall cycle, one DONE cycle, back-to-back accepted
    for (int i = 0; i < 5; i++) begin
      h2.MulStartE = i < 4;
      q2.push_back(i % 2 == 0 && i < 4);
      @(negedge clk);
      e2 = q2.pop_front();
      chk($sformatf("mc2_%0d", i), "StallE", 4'(h2.StallE), 4'(e2));
      chk($sformatf("mc2_%0d", i), "FlushM", 4'(h2.FlushM), 4'(e2));
      chk($sformatf("mc2_%0d", i), "StallF", 4'(h2.StallF), 4'(e2));
      @(posedge clk);
      #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
